// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 round-key sequencer: walks the single-round expansion stage NR times,
// buffers rk[0..NR] and serves them through a registered indexed read port.
module aes_key_schedule_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] key,
    output logic         busy,
    output logic         ready,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         rk_valid,
    output logic         ks_expand_en,
    output logic [3:0]   ks_count,
    output logic [127:0] ks_key_in,
    input  logic [127:0] ks_key_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    state_t         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   cur_key_q, cur_key_d;
    logic [127:0]   rk_q [0:NR];
    logic [127:0]   rk_d [0:NR];
    logic [127:0]   rk_out_q, rk_out_d;
    logic           rk_valid_q, rk_valid_d;
    logic [127:0]   rd_data;
    logic           rd_hit;

    // A key_load in any state restarts the schedule; any partial schedule is simply overwritten.
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        cur_key_d = cur_key_q;
        rk_d      = rk_q;
        case (state_q)
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                for (int i = 1; i <= NR; i++) begin
                    if (rnd_q == 4'(i)) rk_d[i] = ks_key_out;
                end
                cur_key_d = ks_key_out;
                if (rnd_q == NR_L) begin
                    state_d = DONE;
                end else begin
                    rnd_d   = rnd_q + 4'd1;
                    state_d = ISSUE;
                end
            end
            default: ;
        endcase
        if (key_load) begin
            rk_d[0]   = key;
            cur_key_d = key;
            rnd_d     = 4'd1;
            state_d   = ISSUE;
        end
    end

    always_comb begin
        rd_hit  = ready && (rk_idx <= NR_L);
        rd_data = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rk_idx == 4'(i)) rd_data = rk_q[i];
        end
        rk_out_d   = rd_hit ? rd_data : '0;
        rk_valid_d = rd_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rnd_q      <= '0;
            cur_key_q  <= '0;
            rk_out_q   <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            cur_key_q  <= cur_key_d;
            rk_out_q   <= rk_out_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    // Buffer needs no reset: its contents are masked by ready until a full schedule is stored.
    always_ff @(posedge clk) begin
        rk_q <= rk_d;
    end

    assign busy         = (state_q == ISSUE) || (state_q == CAPTURE);
    assign ready        = (state_q == DONE);
    assign ks_expand_en = (state_q == ISSUE);
    assign ks_count     = busy ? rnd_q : 4'd0;
    assign ks_key_in    = busy ? cur_key_q : 128'd0;
    assign rk_out       = rk_out_q;
    assign rk_valid     = rk_valid_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Self-checking bench for aes_key_schedule_ctrl with a behavioural AES-128 expansion stage
// and a word-level FIPS-197 key-expansion reference model.
module tb_aes_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_load;
    logic [127:0] key;
    logic         busy, ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;
    logic         ks_expand_en;
    logic [3:0]   ks_count;
    logic [127:0] ks_key_in;
    logic [127:0] ks_key_out = '0;

    int           test_count = 0;
    int           fail_count = 0;
    int           pulse_q [$];
    logic [7:0]   sbox_tab [0:255];
    logic [127:0] model_rk [0:10];

    aes_key_schedule_ctrl #(.NR(10)) dut (
        .clk(clk), .reset(reset), .key_load(key_load), .key(key),
        .busy(busy), .ready(ready), .rk_idx(rk_idx), .rk_out(rk_out),
        .rk_valid(rk_valid), .ks_expand_en(ks_expand_en), .ks_count(ks_count),
        .ks_key_in(ks_key_in), .ks_key_out(ks_key_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box built from the field inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input int r);
        logic [7:0] c = 8'h01;
        for (int k = 1; k < r; k++) c = xtime(c);
        return c;
    endfunction

    function automatic logic [127:0] stage_round(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(int'(r)), 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Stand-in for the real expansion stage: registered output, held while enable is low.
    always @(posedge clk) begin
        if (ks_expand_en) ks_key_out <= stage_round(ks_key_in, ks_count);
    end

    always @(posedge clk) begin
        if (ks_expand_en) pulse_q.push_back(int'(ks_count));
    end

    task automatic compute_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / 4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] k);
        key      = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic read_check(input string tag, input logic [3:0] idx,
                              input logic [127:0] exp_data, input logic exp_valid);
        rk_idx = idx;
        tick();
        checkOutput({tag, "_data"}, rk_out, exp_data);
        checkOutput({tag, "_valid"}, 128'(rk_valid), 128'(exp_valid));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] fips_key;
        logic [127:0] old10;
        logic [127:0] k;
        logic [3:0]   idx;
        int           cycles;
        int           pulses_before;
        logic         stale_seen;

        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        reset    = 1'b1;
        key_load = 1'b0;
        key      = '0;
        rk_idx   = 4'd0;
        tick();
        tick();
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_ready", 128'(ready), 128'(0));
        checkOutput("rst_rk_out", rk_out, 128'(0));
        checkOutput("rst_rk_valid", 128'(rk_valid), 128'(0));
        checkOutput("rst_expand_en", 128'(ks_expand_en), 128'(0));
        checkOutput("rst_ks_count", 128'(ks_count), 128'(0));
        checkOutput("rst_ks_key_in", ks_key_in, 128'(0));
        reset = 1'b0;

        read_check("notready_idx3", 4'd3, 128'(0), 1'b0);

        // FIPS-197 appendix A.1 vector
        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        compute_model(fips_key);
        pulse_q.delete();
        applyStimulus(fips_key);
        checkOutput("fips_busy_after_load", 128'(busy), 128'(1));
        checkOutput("fips_first_key_in", ks_key_in, fips_key);
        wait_ready(cycles);
        checkOutput("fips_ready_cycles", 128'(cycles), 128'(20));
        checkOutput("fips_busy_done", 128'(busy), 128'(0));
        checkOutput("fips_pulse_count", 128'(pulse_q.size()), 128'(10));
        for (int i = 0; i < pulse_q.size() && i < 10; i++)
            checkOutput("fips_ks_count_seq", 128'(pulse_q[i]), 128'(i + 1));
        read_check("fips_idx1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
        read_check("fips_idx10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        read_check("fips_idx0", 4'd0, fips_key, 1'b1);
        read_check("oob_idx11", 4'd11, 128'(0), 1'b0);
        read_check("oob_idx15", 4'd15, 128'(0), 1'b0);
        for (int i = 0; i <= 10; i++) begin
            rk_idx = 4'(i);
            tick();
            checkOutput("b2b_data", rk_out, model_rk[i]);
            checkOutput("b2b_valid", 128'(rk_valid), 128'(1));
        end

        // Reload while DONE: the stale rk[10] must never come back marked valid
        old10 = model_rk[10];
        k = {$urandom, $urandom, $urandom, $urandom};
        compute_model(k);
        rk_idx = 4'd10;
        applyStimulus(k);
        tick();
        checkOutput("done_reload_ready_drop", 128'(ready), 128'(0));
        cycles     = 1;
        stale_seen = 1'b0;
        while (!ready && cycles < 40) begin
            if (rk_valid && rk_out == old10) stale_seen = 1'b1;
            tick();
            cycles++;
        end
        checkOutput("done_reload_cycles", 128'(cycles), 128'(20));
        checkOutput("done_reload_stale", 128'(stale_seen), 128'(0));
        tick();
        checkOutput("done_reload_idx10", rk_out, model_rk[10]);
        checkOutput("done_reload_valid", 128'(rk_valid), 128'(1));

        // Restart mid-schedule at E7
        applyStimulus({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 6; i++) tick();
        compute_model(128'h000102030405060708090a0b0c0d0e0f);
        applyStimulus(128'h000102030405060708090a0b0c0d0e0f);
        checkOutput("restart_ready_low", 128'(ready), 128'(0));
        wait_ready(cycles);
        checkOutput("restart_cycles", 128'(cycles), 128'(20));
        read_check("restart_idx10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1);
        read_check("restart_idx5_model", 4'd5, model_rk[5], 1'b1);

        // Reset asserted after E9
        applyStimulus({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_busy", 128'(busy), 128'(0));
        checkOutput("midrst_ready", 128'(ready), 128'(0));
        checkOutput("midrst_expand_en", 128'(ks_expand_en), 128'(0));
        checkOutput("midrst_ks_count", 128'(ks_count), 128'(0));
        pulses_before = pulse_q.size();
        for (int i = 0; i < 30; i++) tick();
        checkOutput("midrst_no_pulses", 128'(pulse_q.size()), 128'(pulses_before));
        checkOutput("midrst_still_idle", 128'(busy), 128'(0));

        // Reset wins over a simultaneous key_load
        reset    = 1'b1;
        key_load = 1'b1;
        key      = 128'h1;
        tick();
        reset    = 1'b0;
        key_load = 1'b0;
        checkOutput("rst_vs_load_busy", 128'(busy), 128'(0));
        tick();
        checkOutput("rst_vs_load_idle", 128'(busy), 128'(0));

        // Randomized loads, optional aborts and random reads against the reference model
        for (int it = 0; it < 6; it++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(k);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0, n = $urandom_range(0, 15); j < n; j++) tick();
                k = {$urandom, $urandom, $urandom, $urandom};
                applyStimulus(k);
            end
            compute_model(k);
            wait_ready(cycles);
            checkOutput("rand_cycles", 128'(cycles), 128'(20));
            for (int j = 0; j < 6; j++) begin
                idx = 4'($urandom_range(0, 15));
                if (idx <= 4'd10) read_check("rand_read", idx, model_rk[idx], 1'b1);
                else              read_check("rand_read", idx, 128'(0), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
